// File: rtl/vga_scene_renderer_if.sv
// Scene bus between the game logic and the VGA renderer: object positions,
// per-pipe enables and the lose flag.
interface vga_scene_renderer_if #(
    parameter int NUM_PIPES = 4,
    parameter int COORD_W   = 10
) ();
    logic [NUM_PIPES*COORD_W-1:0] pipe_x;
    logic [NUM_PIPES*COORD_W-1:0] pipe_y;
    logic [NUM_PIPES-1:0]         pipe_en;
    logic [COORD_W-1:0]           bird_x;
    logic [COORD_W-1:0]           bird_y;
    logic                         lose;

    // Game logic publishes the scene
    modport master (
        output pipe_x, pipe_y, pipe_en, bird_x, bird_y, lose
    );

    // Renderer consumes the scene
    modport slave (
        input pipe_x, pipe_y, pipe_en, bird_x, bird_y, lose
    );
endinterface

// File: rtl/vga_scene_renderer.sv
// VGA timing generator and scene compositor for the Flappy display path.
// Produces sync and 1-bit RGB for a bird box, gapped pipes and a sky
// background; scene positions are captured once per frame at the start of
// vertical blanking so the picture never tears.
module vga_scene_renderer #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int NUM_PIPES  = 4,
    parameter int COORD_W    = 10,
    parameter int PIPE_W     = 80,
    parameter int GAP_H      = 100,
    parameter int BIRD_HALF  = 8,
    parameter int FLASH_LOG2 = 4
) (
    input  logic               board_clk,
    input  logic               Reset,
    vga_scene_renderer_if.slave scene,
    output logic               vga_h_sync,
    output logic               vga_v_sync,
    output logic               vga_r,
    output logic               vga_g,
    output logic               vga_b,
    output logic               in_display,
    output logic [COORD_W-1:0] counter_x,
    output logic [COORD_W-1:0] counter_y,
    output logic               frame_pulse
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW      = COORD_W + 2;
    localparam int FW      = FLASH_LOG2 + 1;

    localparam logic signed [SW-1:0] BIRD_S   = SW'(BIRD_HALF);
    localparam logic signed [SW-1:0] PIPE_M1  = SW'(PIPE_W - 1);
    localparam logic signed [SW-1:0] GAP_S    = SW'(GAP_H);

    logic [DIV_W-1:0]             div_q, div_d;
    logic                         tick;
    logic [COORD_W-1:0]           x_q, x_d, y_q, y_d;
    logic                         x_last, y_last, load;

    logic [NUM_PIPES*COORD_W-1:0] pipe_x_q, pipe_y_q;
    logic [NUM_PIPES-1:0]         pipe_en_q;
    logic [COORD_W-1:0]           bird_x_q, bird_y_q;
    logic [FW-1:0]                frame_cnt_q;
    logic                         frame_pulse_q;

    logic signed [SW-1:0]         xs, ys, dx, dy, pxs, pys;
    logic                         bird_hit, pipe_hit, active, h_act, v_act, flash;
    logic [2:0]                   colour_d;

    logic                         h_sync_q, v_sync_q, disp_q;
    logic [2:0]                   colour_q;

    // Pixel-tick divider and raster counter next-state; the shadow load fires
    // on the tick that moves the raster to the first blanked line.
    always_comb begin
        tick   = (div_q == DIV_W'(CLK_DIV - 1));
        div_d  = tick ? '0 : div_q + 1'b1;
        x_last = (x_q == COORD_W'(H_TOTAL - 1));
        y_last = (y_q == COORD_W'(V_TOTAL - 1));
        x_d    = x_last ? '0 : x_q + 1'b1;
        y_d    = y_q;
        if (x_last) begin
            y_d = y_last ? '0 : y_q + 1'b1;
        end
        load   = tick && x_last && (y_q == COORD_W'(V_ACTIVE - 1));
    end

    // Hit tests and colour selection for the pixel currently addressed; the
    // two extra signed bits keep pipe and bird edges from wrapping around.
    always_comb begin
        xs       = $signed({2'b00, x_q});
        ys       = $signed({2'b00, y_q});
        dx       = xs - $signed({2'b00, bird_x_q});
        dy       = ys - $signed({2'b00, bird_y_q});
        bird_hit = (dx >= -BIRD_S) && (dx <= BIRD_S) &&
                   (dy >= -BIRD_S) && (dy <= BIRD_S);
        pipe_hit = 1'b0;
        pxs      = '0;
        pys      = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            pxs = $signed({2'b00, pipe_x_q[i*COORD_W +: COORD_W]});
            pys = $signed({2'b00, pipe_y_q[i*COORD_W +: COORD_W]});
            if (pipe_en_q[i] && (xs >= pxs) && (xs <= pxs + PIPE_M1) &&
                ((ys < pys) || (ys >= pys + GAP_S))) begin
                pipe_hit = 1'b1;
            end
        end
        active = (x_q < COORD_W'(H_ACTIVE)) && (y_q < COORD_W'(V_ACTIVE));
        h_act  = (x_q >= COORD_W'(H_ACTIVE + H_FP)) &&
                 (x_q <  COORD_W'(H_ACTIVE + H_FP + H_SYNC));
        v_act  = (y_q >= COORD_W'(V_ACTIVE + V_FP)) &&
                 (y_q <  COORD_W'(V_ACTIVE + V_FP + V_SYNC));
        flash  = scene.lose && frame_cnt_q[FLASH_LOG2];
        if (!active) begin
            colour_d = 3'b000;
        end else if (bird_hit) begin
            colour_d = 3'b100;
        end else if (pipe_hit) begin
            colour_d = 3'b010;
        end else if (flash) begin
            colour_d = 3'b111;
        end else begin
            colour_d = 3'b001;
        end
    end

    // Divider and raster position registers
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            if (tick) begin
                x_q <= x_d;
                y_q <= y_d;
            end
        end
    end

    // Per-frame scene snapshot, frame counter and the one-cycle load strobe
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            pipe_x_q      <= '0;
            pipe_y_q      <= '0;
            pipe_en_q     <= '0;
            bird_x_q      <= '0;
            bird_y_q      <= '0;
            frame_cnt_q   <= '0;
            frame_pulse_q <= 1'b0;
        end else begin
            frame_pulse_q <= load;
            if (load) begin
                pipe_x_q    <= scene.pipe_x;
                pipe_y_q    <= scene.pipe_y;
                pipe_en_q   <= scene.pipe_en;
                bird_x_q    <= scene.bird_x;
                bird_y_q    <= scene.bird_y;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    // Sync, colour and active flag registered together so they stay aligned
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            h_sync_q <= 1'b1;
            v_sync_q <= 1'b1;
            disp_q   <= 1'b0;
            colour_q <= 3'b000;
        end else if (tick) begin
            h_sync_q <= ~h_act;
            v_sync_q <= ~v_act;
            disp_q   <= active;
            colour_q <= colour_d;
        end
    end

    assign vga_h_sync  = h_sync_q;
    assign vga_v_sync  = v_sync_q;
    assign vga_r       = colour_q[2];
    assign vga_g       = colour_q[1];
    assign vga_b       = colour_q[0];
    assign in_display  = disp_q;
    assign counter_x   = x_q;
    assign counter_y   = y_q;
    assign frame_pulse = frame_pulse_q;
endmodule

// File: tb/tb_vga_scene_renderer.sv
// Directed bench for vga_scene_renderer using a shrunken raster so several
// whole frames fit in a short run. A small position model tracks where the
// raster should be after each pixel tick.
module tb_vga_scene_renderer;
    localparam int CW  = 10;
    localparam int NP  = 2;
    localparam int HA  = 40, HFP = 4, HS = 6, HBP = 2;
    localparam int VA  = 30, VFP = 2, VS = 2, VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] BLU = 3'b001;
    localparam logic [2:0] WHT = 3'b111;
    localparam logic [2:0] BLK = 3'b000;

    logic          board_clk = 1'b0;
    logic          Reset;
    logic          vga_h_sync, vga_v_sync, vga_r, vga_g, vga_b;
    logic          in_display, frame_pulse;
    logic [CW-1:0] counter_x, counter_y;

    int passCount  = 0;
    int checkCount = 0;
    int mx = 0;
    int my = 0;

    vga_scene_renderer_if #(.NUM_PIPES(NP), .COORD_W(CW)) scene ();

    vga_scene_renderer #(
        .CLK_DIV(2),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .NUM_PIPES(NP), .COORD_W(CW),
        .PIPE_W(10), .GAP_H(8), .BIRD_HALF(2), .FLASH_LOG2(1)
    ) dut (
        .board_clk(board_clk),
        .Reset(Reset),
        .scene(scene),
        .vga_h_sync(vga_h_sync),
        .vga_v_sync(vga_v_sync),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .in_display(in_display),
        .counter_x(counter_x),
        .counter_y(counter_y),
        .frame_pulse(frame_pulse)
    );

    always #5 board_clk = ~board_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void advanceModel();
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
    endfunction

    task automatic stepTick();
        @(posedge board_clk); #1;
        @(posedge board_clk); #1;
        advanceModel();
    endtask

    task automatic runTo(input int x, input int y);
        int guard = 0;
        while (!(mx == x && my == y) && guard < 2 * HT * VT) begin
            stepTick();
            guard++;
        end
        checkOutput("position", {6'd0, counter_y, 6'd0, counter_x},
                    {16'(my), 16'(mx)});
    endtask

    task automatic applyStimulus(input int x, input int y);
        runTo(x, y);
        stepTick();
    endtask

    task automatic checkPixel(input string tag, input int x, input int y, input logic [2:0] exp);
        applyStimulus(x, y);
        checkOutput(tag, {29'd0, vga_r, vga_g, vga_b}, {29'd0, exp});
    endtask

    initial begin
        int lowCnt, firstX, firstVx, firstVy, fpErr, fpCnt;
        Reset         = 1'b1;
        scene.pipe_x  = '0;
        scene.pipe_y  = '0;
        scene.pipe_en = '0;
        scene.bird_x  = '0;
        scene.bird_y  = '0;
        scene.lose    = 1'b0;
        repeat (3) @(posedge board_clk);
        #1;
        checkOutput("rst_hsync", 32'(vga_h_sync), 32'd1);
        checkOutput("rst_vsync", 32'(vga_v_sync), 32'd1);
        checkOutput("rst_rgb", {29'd0, vga_r, vga_g, vga_b}, 32'd0);
        checkOutput("rst_disp", 32'(in_display), 32'd0);
        checkOutput("rst_pulse", 32'(frame_pulse), 32'd0);
        checkOutput("rst_cx", 32'(counter_x), 32'd0);
        checkOutput("rst_cy", 32'(counter_y), 32'd0);

        scene.pipe_x  = {10'd35, 10'd12};
        scene.pipe_y  = {10'd0, 10'd10};
        scene.pipe_en = 2'b11;
        scene.bird_x  = 10'd26;
        scene.bird_y  = 10'd25;
        Reset = 1'b0;
        @(posedge board_clk); #1;
        checkOutput("no_tick_yet", 32'(counter_x), 32'd0);
        @(posedge board_clk); #1;
        advanceModel();
        checkOutput("first_tick", 32'(counter_x), 32'd1);

        // one full line of horizontal sync
        runTo(0, 1);
        lowCnt = 0;
        firstX = -1;
        repeat (HT) begin
            stepTick();
            if (vga_h_sync === 1'b0) begin
                if (lowCnt == 0) firstX = mx;
                lowCnt++;
            end
        end
        checkOutput("hsync_width", 32'(lowCnt), 32'(HS));
        checkOutput("hsync_start", 32'(firstX), 32'(HA + HFP + 1));

        // one full frame of vertical sync and frame pulses
        lowCnt  = 0;
        firstVx = -1;
        firstVy = -1;
        fpErr   = 0;
        fpCnt   = 0;
        repeat (HT * VT) begin
            stepTick();
            if (vga_v_sync === 1'b0) begin
                if (lowCnt == 0) begin
                    firstVx = mx;
                    firstVy = my;
                end
                lowCnt++;
            end
            if (frame_pulse === 1'b1) fpCnt++;
            if (frame_pulse !== ((mx == 0 && my == VA) ? 1'b1 : 1'b0)) fpErr++;
        end
        checkOutput("vsync_ticks", 32'(lowCnt), 32'(VS * HT));
        checkOutput("vsync_start_y", 32'(firstVy), 32'(VA + VFP));
        checkOutput("vsync_start_x", 32'(firstVx), 32'd1);
        checkOutput("pulse_count", 32'(fpCnt), 32'd1);
        checkOutput("pulse_place", 32'(fpErr), 32'd0);

        // frame 1: pipe 0 at x=12, moved mid-frame without tearing
        checkPixel("old_pipe", 14, 5, GRN);
        scene.pipe_x[9:0] = 10'd25;
        checkPixel("no_tear", 14, 8, GRN);
        runTo(0, VA);
        checkOutput("pulse_high", 32'(frame_pulse), 32'd1);
        @(posedge board_clk); #1;
        checkOutput("pulse_width", 32'(frame_pulse), 32'd0);
        @(posedge board_clk); #1;
        advanceModel();

        // frame 2: pipe0 (25,10), pipe1 (35,0), bird (26,25)
        checkPixel("pipe_left", 25, 5, GRN);
        checkOutput("disp_on", 32'(in_display), 32'd1);
        checkPixel("pipe_right", 34, 5, GRN);
        checkPixel("past_pipe", 35, 5, BLU);
        checkPixel("blank", 45, 5, BLK);
        checkOutput("disp_off", 32'(in_display), 32'd0);
        checkPixel("old_x_gone", 14, 6, BLU);
        checkPixel("gap_above", 25, 9, GRN);
        checkPixel("gap_top", 25, 10, BLU);
        checkPixel("gap_bottom", 25, 17, BLU);
        checkPixel("gap_below", 25, 18, GRN);
        checkPixel("no_wrap0", 0, 20, BLU);
        checkPixel("no_wrap4", 4, 20, BLU);
        checkPixel("edge_pipe", 35, 20, GRN);
        checkPixel("edge_last", 39, 20, GRN);
        checkPixel("edge_clip", 40, 20, BLK);
        checkPixel("bird_out", 23, 25, BLU);
        checkPixel("bird_edge", 24, 25, RED);
        checkPixel("bird_prio", 26, 25, RED);
        checkPixel("bird_below", 26, 28, GRN);
        scene.lose = 1'b1;
        checkPixel("flash_on", 5, 29, WHT);
        checkPixel("flash_pipe", 25, 29, GRN);

        // frame 3 (count 3) still flashing, frame 4 (count 4) blue again
        checkPixel("flash_f3", 5, 3, WHT);
        checkPixel("flash_bird", 26, 25, RED);
        checkPixel("flash_off", 5, 3, BLU);
        checkPixel("flash_pipe2", 25, 3, GRN);

        // reset in mid-frame restarts the raster at the origin
        runTo(20, 10);
        Reset = 1'b1;
        #2;
        checkOutput("mid_rst_cx", 32'(counter_x), 32'd0);
        checkOutput("mid_rst_cy", 32'(counter_y), 32'd0);
        checkOutput("mid_rst_rgb", {29'd0, vga_r, vga_g, vga_b}, 32'd0);
        @(posedge board_clk); #1;
        Reset = 1'b0;
        mx = 0;
        my = 0;
        fpCnt = 0;
        repeat (VA * HT - 1) begin
            stepTick();
            if (frame_pulse === 1'b1) fpCnt++;
        end
        checkOutput("early_pulse", 32'(fpCnt), 32'd0);
        stepTick();
        checkOutput("restart_pulse", 32'(frame_pulse), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
